scene_rom_arbiter: RTL and testbench
====================================

Name: scene_rom_arbiter

Overview:
- Shares the dual-port scene ROM (17-bit word address, 32-bit data) between NREQ read clients: header reader, light fetch, vertex/face fetch, material fetch.
- Round-robin arbitration with one grant per cycle on port A.
- Read data is routed back to the granted client with a per-client valid strobe after the ROM's fixed read latency.
- Sits between the scene ROM and all fetch engines; it is the only block that drives ROM address/rden.

Parameters:
- NREQ, 4, number of requesting clients (2..8)
- AW, 17, ROM word-address width
- DW, 32, ROM data width
- READ_LAT, 1, cycles from rden/address sampled at a clk edge to q valid (1..3)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset; reset==0 at a clk edge resets the block
- req  in  NREQ  per-client read request; held until granted
- req_addr  in  NREQ*AW  per-client word address, client i in bits [i*AW +: AW]; stable while req[i]
- gnt  out  NREQ  one-hot grant, combinational, same cycle as winning req
- rvalid  out  NREQ  per-client read-data strobe, one cycle each
- rdata  out  NREQ*DW  per-client read data, valid when the matching rvalid bit is high
- address_a  out  AW  ROM port A address
- rden_a  out  1  ROM port A read enable
- address_b  out  AW  ROM port B address
- rden_b  out  1  ROM port B read enable
- q_a  in  DW  ROM port A data
- q_b  in  DW  ROM port B data
- busy  out  1  any req high or any read in flight

Behaviour:
- Reset values: rr_ptr=0; in-flight pipeline cleared; rvalid=0; gnt=0; rden_a/rden_b=0; address_a/address_b=0; busy=0.
- Arbitration (combinational):
  - Scan req starting at rr_ptr, wrapping modulo NREQ; the first set bit wins.
  - gnt[win]=1, rden_a=1, address_a=req_addr[win].
  - With no req: gnt=0, rden_a=0, address_a=0.
- rr_ptr update at the clk edge after a grant: rr_ptr <= (win+1) mod NREQ; wrap NREQ-1 -> 0. Unchanged when nothing is granted.
- Client handshake: the client drops req or changes the address on the cycle after it sees gnt. One request yields exactly one rvalid.
- Return path:
  - A shift register READ_LAT deep carries {valid, client id, port}.
  - rvalid[id] is high exactly READ_LAT cycles after the grant cycle.
  - rdata[id] equals q_a (or q_b) combinationally in that cycle; rdata for non-valid clients is don't-care, held at 0.
- Throughput: back-to-back grants every cycle. A single continuously requesting client gets every cycle only when no other req is set.
- Fairness: with all NREQ requesting, each client is granted once per NREQ cycles.
- Reset mid-operation: reads in flight are discarded and no rvalid follows. Clients must reissue.
- Ownership: req_addr is not registered; ROM address timing is owned by the ROM.

Optional Feature:
- SCENE_ARB_PORTB_EN defined:
  - Port B grants a second winner in the same cycle: the next set req after the port-A winner in round-robin order.
  - rden_b=1 and address_b=that client's address; both bits are set in gnt.
  - rr_ptr advances past the port-B winner.
  - The return path records the port so that rdata comes from q_b.
- SCENE_ARB_PORTB_EN undefined: rden_b=0, address_b=0 constantly, and q_b is ignored.

Decomposition:
- Package scene_rom_pkg:
  - SCENE_AW=17, SCENE_DW=32.
  - Client-ID enum: CLI_HDR, CLI_LIGHT, CLI_GEOM, CLI_MAT.
  - Header word indices 0..10: HDR_SIZE, HDR_NUMV, HDR_NUMF, HDR_NUML, HDR_LOFF, HDR_VOFF, HDR_NVOFF, HDR_FOFF, HDR_NFOFF, HDR_MOFF, HDR_MFOFF.
  - HDR_WORDS=11.
- Sub-module rr_pick: a combinational round-robin priority encoder (req vector, start pointer, optional mask -> one-hot, index, any). It is instantiated twice when the port-B feature is enabled.

Test Plan:
- Reset held low 3 cycles with req=4'b1111 -> gnt=0, rden_a=0, rvalid=0 throughout; after release, the first grant goes to client 0.
- Single client 2 requests addr 17'h00005 once, READ_LAT=1 -> gnt=4'b0100 at cycle t, address_a=5, rden_a=1; at t+1 rvalid=4'b0100 and rdata[2]=q_a.
- req=4'b1111 held 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3; each client receives two rvalids.
- rr_ptr=3, req=4'b1001 -> client 3 is granted, then client 0 (wrap); afterwards rr_ptr=1.
- A grant in cycle t, then reset low at t+1 with READ_LAT=2 -> no rvalid at t+2; busy=0 after reset.
- With SCENE_ARB_PORTB_EN, req=4'b0110 and rr_ptr=0 -> port A serves client 1 and port B serves client 2 in the same cycle; gnt=4'b0110; rdata[1]=q_a and rdata[2]=q_b after READ_LAT.

Source files
------------

// File: rtl/scene_rom_pkg.sv
// Shared scene ROM constants: geometry, client ids, header word layout.
// Imported by the arbiter, its interface and the fetch engines.
package scene_rom_pkg;

  localparam int SCENE_AW = 17;
  localparam int SCENE_DW = 32;

  typedef enum logic [1:0] {
    CLI_HDR,
    CLI_LIGHT,
    CLI_GEOM,
    CLI_MAT
  } cli_e;

  typedef enum logic [3:0] {
    HDR_SIZE,
    HDR_NUMV,
    HDR_NUMF,
    HDR_NUML,
    HDR_LOFF,
    HDR_VOFF,
    HDR_NVOFF,
    HDR_FOFF,
    HDR_NFOFF,
    HDR_MOFF,
    HDR_MFOFF
  } hdr_e;

  localparam int HDR_WORDS = 11;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/scene_rom_arbiter_if.sv
// Client request/return bus plus the dual ROM port of the scene ROM arbiter.
// slave = arbiter side, master = clients and ROM side.
interface scene_rom_arbiter_if
  import scene_rom_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = SCENE_AW,
  parameter int DW   = SCENE_DW
);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [NREQ*DW-1:0] rdata;
  logic [AW-1:0]      address_a;
  logic               rden_a;
  logic [AW-1:0]      address_b;
  logic               rden_b;
  logic [DW-1:0]      q_a;
  logic [DW-1:0]      q_b;
  logic               busy;

  modport slave (
    input  req, req_addr, q_a, q_b,
    output gnt, rvalid, rdata,
    output address_a, rden_a,
    output address_b, rden_b,
    output busy
  );

  modport master (
    output req, req_addr, q_a, q_b,
    input  gnt, rvalid, rdata,
    input  address_a, rden_a,
    input  address_b, rden_b,
    input  busy
  );

endinterface

// File: rtl/scene_rom_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set, unmasked req bit
// at or after start (wrapping) wins.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    k      = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(start) + i) % N);
      if (!any && req[k] && mask[k]) begin
        any       = 1'b1;
        onehot[k] = 1'b1;
        idx       = k;
      end
    end
  end

endmodule

// File: rtl/scene_rom_arbiter.sv
// Round-robin read arbiter in front of the dual-port scene ROM.
// Define SCENE_ARB_PORTB_EN to grant a second client per cycle on port B.
module scene_rom_arbiter
  import scene_rom_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = SCENE_AW,
  parameter int DW       = SCENE_DW,
  parameter int READ_LAT = 1
) (
  input logic              clk,
  input logic              reset,
  scene_rom_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ALL = '1;

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   ptr_nxt;
  logic [NREQ-1:0] oh_a;
  logic [NREQ-1:0] oh_b;
  logic [IW-1:0]   idx_a;
  logic [IW-1:0]   idx_b;
  logic            any_a;
  logic            any_b;

  logic [NREQ-1:0] ga_pipe [READ_LAT];
  logic [NREQ-1:0] gb_pipe [READ_LAT];
  logic [NREQ-1:0] va;
  logic [NREQ-1:0] vb;
  logic            inflight;
  logic [NREQ*DW-1:0] rdata_c;

  rr_pick #(.N(NREQ)) u_pick_a (
    .req    (bus.req),
    .start  (rr_ptr),
    .mask   (ALL),
    .onehot (oh_a),
    .idx    (idx_a),
    .any    (any_a)
  );

`ifdef SCENE_ARB_PORTB_EN
  logic [IW-1:0] start_b;

  // Port B continues the scan right after the port-A winner.
  assign start_b = IW'(rr_next(int'(idx_a), NREQ));

  rr_pick #(.N(NREQ)) u_pick_b (
    .req    (bus.req),
    .start  (start_b),
    .mask   (~oh_a),
    .onehot (oh_b),
    .idx    (idx_b),
    .any    (any_b)
  );
`else
  assign oh_b  = '0;
  assign idx_b = '0;
  assign any_b = 1'b0;
`endif

  always_comb begin
    ptr_nxt = rr_ptr;
    if (any_b)
      ptr_nxt = IW'(rr_next(int'(idx_b), NREQ));
    else if (any_a)
      ptr_nxt = IW'(rr_next(int'(idx_a), NREQ));
  end

  assign bus.gnt    = reset ? (oh_a | oh_b) : '0;
  assign bus.rden_a = reset & any_a;
  assign bus.rden_b = reset & any_b;

  assign bus.address_a = (reset && any_a) ?
    bus.req_addr[idx_a*AW +: AW] : '0;
  assign bus.address_b = (reset && any_b) ?
    bus.req_addr[idx_b*AW +: AW] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        ga_pipe[i] <= '0;
        gb_pipe[i] <= '0;
      end
    end else begin
      rr_ptr     <= ptr_nxt;
      ga_pipe[0] <= oh_a;
      gb_pipe[0] <= oh_b;
      for (int i = 1; i < READ_LAT; i++) begin
        ga_pipe[i] <= ga_pipe[i-1];
        gb_pipe[i] <= gb_pipe[i-1];
      end
    end
  end

  assign va = ga_pipe[READ_LAT-1];
  assign vb = gb_pipe[READ_LAT-1];

  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < READ_LAT; i++)
      inflight = inflight | (|ga_pipe[i]) | (|gb_pipe[i]);
  end

  always_comb begin
    rdata_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (reset && va[i])
        rdata_c[i*DW +: DW] = bus.q_a;
      else if (reset && vb[i])
        rdata_c[i*DW +: DW] = bus.q_b;
    end
  end

  assign bus.rdata  = rdata_c;
  assign bus.rvalid = reset ? (va | vb) : '0;
  assign bus.busy   = reset & ((|bus.req) | inflight);

endmodule

// File: tb/tb_scene_rom_arbiter.sv
// Directed bench for scene_rom_arbiter: READ_LAT=1 and READ_LAT=2 instances
// share one stimulus stream.
module tb_scene_rom_arbiter;
  import scene_rom_pkg::*;

  localparam int N  = 4;
  localparam int AW = SCENE_AW;
  localparam int DW = SCENE_DW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [DW-1:0]   q_a;
  logic [DW-1:0]   q_b;

  int nvec = 0;
  int nerr = 0;
  int cnt [N];
  logic [3:0] exp_seq [8];
  int exp_cnt;
  logic portb;

  scene_rom_arbiter_if #(.NREQ(N), .AW(AW), .DW(DW)) b1 ();
  scene_rom_arbiter_if #(.NREQ(N), .AW(AW), .DW(DW)) b2 ();

  assign b1.req = req;
  assign b1.req_addr = req_addr;
  assign b1.q_a = q_a;
  assign b1.q_b = q_b;
  assign b2.req = req;
  assign b2.req_addr = req_addr;
  assign b2.q_a = q_a;
  assign b2.q_b = q_b;

  scene_rom_arbiter #(
    .NREQ(N), .AW(AW), .DW(DW), .READ_LAT(1)
  ) dut1 (.clk(clk), .reset(reset), .bus(b1));

  scene_rom_arbiter #(
    .NREQ(N), .AW(AW), .DW(DW), .READ_LAT(2)
  ) dut2 (.clk(clk), .reset(reset), .bus(b2));

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef SCENE_ARB_PORTB_EN
    portb = 1'b1;
    exp_cnt = 4;
    exp_seq = '{4'b0011, 4'b1100, 4'b0011, 4'b1100,
                4'b0011, 4'b1100, 4'b0011, 4'b1100};
`else
    portb = 1'b0;
    exp_cnt = 2;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
    for (int i = 0; i < N; i++) cnt[i] = 0;
    q_a = 32'hCAFE_0A0A;
    q_b = 32'h0B0B_BEEF;
    req = 4'b1111;
    req_addr = {17'h00103, 17'h00102, 17'h00101, 17'h00100};

    // reset held low with every client requesting
    for (int c = 0; c < 3; c++) begin
      cyc();
      #1;
      chk("rst_gnt", 32'(b1.gnt), 32'd0);
      chk("rst_rden_a", 32'(b1.rden_a), 32'd0);
      chk("rst_rvalid1", 32'(b1.rvalid), 32'd0);
      chk("rst_rvalid2", 32'(b2.rvalid), 32'd0);
      chk("rst_busy", 32'(b1.busy), 32'd0);
    end

    cyc();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      #1;
      chk("rr_gnt1", 32'(b1.gnt), 32'(exp_seq[k]));
      chk("rr_gnt2", 32'(b2.gnt), 32'(exp_seq[k]));
      chk("rr_rvalid1", 32'(b1.rvalid),
          (k >= 1) ? 32'(exp_seq[k-1]) : 32'd0);
      chk("rr_rvalid2", 32'(b2.rvalid),
          (k >= 2) ? 32'(exp_seq[k-2]) : 32'd0);
      for (int i = 0; i < N; i++) begin
        cnt[i] += int'(b1.rvalid[i]);
        if (b1.rvalid[i])
          chk("rr_rdata1", b1.rdata[i*DW +: DW],
              (portb && (i % 2 == 1)) ? q_b : q_a);
      end
    end

    cyc();
    req = 4'b0000;
    #1;
    chk("tail_gnt", 32'(b1.gnt), 32'd0);
    chk("tail_rvalid1", 32'(b1.rvalid), 32'(exp_seq[7]));
    chk("tail_rvalid2", 32'(b2.rvalid), 32'(exp_seq[6]));
    for (int i = 0; i < N; i++) cnt[i] += int'(b1.rvalid[i]);
    for (int i = 0; i < N; i++) chk("fair_cnt", 32'(cnt[i]), 32'(exp_cnt));

    cyc();
    #1;
    chk("drain_rvalid1", 32'(b1.rvalid), 32'd0);
    chk("drain_rvalid2", 32'(b2.rvalid), 32'(exp_seq[7]));
    chk("drain_busy1", 32'(b1.busy), 32'd0);
    chk("drain_busy2", 32'(b2.busy), 32'd1);

    // single client 2, address 5
    cyc();
    req = 4'b0100;
    req_addr[2*AW +: AW] = 17'h00005;
    #1;
    chk("one_gnt", 32'(b1.gnt), 32'b0100);
    chk("one_addr_a", 32'(b1.address_a), 32'h5);
    chk("one_rden_a", 32'(b1.rden_a), 32'd1);
    chk("one_addr_b", 32'(b1.address_b), 32'd0);
    chk("one_rden_b", 32'(b1.rden_b), 32'd0);
    chk("one_busy", 32'(b1.busy), 32'd1);

    cyc();
    req = 4'b0000;
    #1;
    chk("one_rvalid", 32'(b1.rvalid), 32'b0100);
    chk("one_rdata2", b1.rdata[2*DW +: DW], q_a);
    chk("one_rdata0", b1.rdata[0 +: DW], 32'd0);
    chk("one_gnt_off", 32'(b1.gnt), 32'd0);

    // rr_ptr now 3: wrap from client 3 to client 0
    cyc();
    req = 4'b1001;
    #1;
    chk("wrap_gnt_a", 32'(b1.gnt), portb ? 32'b1001 : 32'b1000);
    if (!portb) begin
      cyc();
      req = 4'b0001;
      #1;
      chk("wrap_gnt_b", 32'(b1.gnt), 32'b0001);
    end

    cyc();
    req = 4'b1111;
    #1;
    chk("wrap_ptr1", 32'(b1.gnt), portb ? 32'b0110 : 32'b0010);
    chk("wrap_addr_a", 32'(b1.address_a), 32'h00101);
    chk("wrap_addr_b", 32'(b1.address_b), portb ? 32'h5 : 32'd0);
    chk("wrap_rden_b", 32'(b1.rden_b), portb ? 32'd1 : 32'd0);

    cyc();
    req = 4'b0000;
    #1;
    chk("wrap_rvalid", 32'(b1.rvalid), portb ? 32'b0110 : 32'b0010);
    chk("wrap_rdata1", b1.rdata[1*DW +: DW], q_a);
    chk("wrap_rdata2", b1.rdata[2*DW +: DW], portb ? q_b : 32'd0);

    cyc();
    cyc();

    // grant, then reset with the READ_LAT=2 read in flight
    cyc();
    req = 4'b0001;
    #1;
    chk("mid_gnt2", 32'(b2.gnt), 32'b0001);
    chk("mid_busy2", 32'(b2.busy), 32'd1);

    cyc();
    req = 4'b0000;
    reset = 1'b0;
    #1;
    chk("mid_rvalid2_a", 32'(b2.rvalid), 32'd0);

    cyc();
    reset = 1'b1;
    #1;
    chk("mid_rvalid2_b", 32'(b2.rvalid), 32'd0);
    chk("mid_busy2_b", 32'(b2.busy), 32'd0);

    cyc();
    #1;
    chk("mid_rvalid2_c", 32'(b2.rvalid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
